// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: reset constants, FSM encodings and the IF/ID payload.
package fetch_stage_pkg;

   localparam int          XLEN          = 32;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
   } ifid_t;

   // Fetch addresses are always word aligned; low target bits are discarded.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a new instruction, hold under stall, flush on redirect.
module if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  i_load,
   input  logic  i_flush,
   input  logic  i_stall,
   input  ifid_t i_data,
   output logic  o_valid,
   output ifid_t o_data
);

   logic  r_valid;
   ifid_t r_data;

   // Flush beats load beats drain; a stalled live entry keeps every bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid           <= 1'b0;
         r_data.instr      <= NOP_INSTR;
         r_data.pc         <= '0;
         r_data.pc_plus4   <= '0;
      end else if (i_flush) begin
         r_valid           <= 1'b0;
         r_data.instr      <= NOP_INSTR;
      end else if (i_load) begin
         r_valid           <= 1'b1;
         r_data            <= i_data;
      end else if (r_valid && !i_stall) begin
         r_valid           <= 1'b0;
         r_data.instr      <= NOP_INSTR;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem request FSM, kill flag and hold buffer
// feeding the IF/ID register.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_stall,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4
);

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic        r_kill;
   logic        w_kill_nxt;
   logic [31:0] r_hold_buf;
   logic        w_hold_capture;
   logic [31:0] w_pc_plus4;
   logic        w_slot_free;
   logic        w_load;
   logic        w_flush;
   ifid_t       w_load_data;
   ifid_t       w_ifid_q;

   assign w_pc_plus4     = r_pc + 32'd4;
   assign w_slot_free    = !id_valid || !id_stall;
   assign imem_req_valid = (r_state == ST_FETCH) && !reset;
   assign imem_addr      = r_pc;

   always_comb begin
      w_state_nxt          = r_state;
      w_pc_nxt             = r_pc;
      w_kill_nxt           = r_kill;
      w_hold_capture       = 1'b0;
      w_load               = 1'b0;
      w_flush              = 1'b0;
      w_load_data.instr    = imem_rsp_data;
      w_load_data.pc       = r_pc;
      w_load_data.pc_plus4 = w_pc_plus4;
      if (r_state == ST_HOLD) begin
         w_load_data.instr = r_hold_buf;
      end

      if (redirect_valid) begin
         // Redirect wins over everything; an in-flight request must be killed on return.
         w_pc_nxt = align_pc(redirect_pc);
         w_flush  = 1'b1;
         case (r_state)
            ST_FETCH: begin
               if (imem_req_ready) begin
                  w_kill_nxt  = 1'b1;
                  w_state_nxt = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_rsp_valid) begin
                  w_kill_nxt  = 1'b0;
                  w_state_nxt = ST_FETCH;
               end else begin
                  w_kill_nxt  = 1'b1;
               end
            end
            default: begin
               w_kill_nxt  = 1'b0;
               w_state_nxt = ST_FETCH;
            end
         endcase
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (imem_req_ready) begin
                  w_state_nxt = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_rsp_valid) begin
                  if (r_kill) begin
                     w_kill_nxt  = 1'b0;
                     w_state_nxt = ST_FETCH;
                  end else if (w_slot_free) begin
                     w_load      = 1'b1;
                     w_pc_nxt    = w_pc_plus4;
                     w_state_nxt = ST_FETCH;
                  end else begin
                     w_hold_capture = 1'b1;
                     w_state_nxt    = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (w_slot_free) begin
                  w_load      = 1'b1;
                  w_pc_nxt    = w_pc_plus4;
                  w_state_nxt = ST_FETCH;
               end
            end
            default: begin
               w_state_nxt = ST_FETCH;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_FETCH;
         r_pc    <= RESET_PC;
         r_kill  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_kill  <= w_kill_nxt;
      end
   end

   // The hold buffer is pure data; its contents only matter while in HOLD.
   always_ff @(posedge clk) begin
      if (w_hold_capture) begin
         r_hold_buf <= imem_rsp_data;
      end
   end

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_load),
      .i_flush (w_flush),
      .i_stall (id_stall),
      .i_data  (w_load_data),
      .o_valid (id_valid),
      .o_data  (w_ifid_q)
   );

   assign id_instr    = w_ifid_q.instr;
   assign id_pc       = w_ifid_q.pc;
   assign id_pc_plus4 = w_ifid_q.pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run scored against
// a program-order model (sequential PCs, restarted at each aligned redirect target).
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, rsp_valid, redir_v, stall;
   logic [31:0] addr, rsp_data, redir_pc;
   logic        id_valid;
   logic [31:0] id_instr, id_pc, id_pc4;

   logic        b_req_valid, b_req_ready, b_rsp_valid, b_redir_v, b_stall;
   logic [31:0] b_addr, b_rsp_data, b_redir_pc;
   logic        b_id_valid;
   logic [31:0] b_id_instr, b_id_pc, b_id_pc4;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fetch_stage u_dut (
      .clk(clk), .reset(reset),
      .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_addr(addr),
      .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
      .redirect_valid(redir_v), .redirect_pc(redir_pc), .id_stall(stall),
      .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc4)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
      .clk(clk), .reset(reset),
      .imem_req_valid(b_req_valid), .imem_req_ready(b_req_ready), .imem_addr(b_addr),
      .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(b_rsp_data),
      .redirect_valid(b_redir_v), .redirect_pc(b_redir_pc), .id_stall(b_stall),
      .id_valid(b_id_valid), .id_instr(b_id_instr), .id_pc(b_id_pc), .id_pc_plus4(b_id_pc4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_pc, o_addr, hs_addr, snap_instr, snap_pc, snap_pc4;
      logic        outst, hs, rsp_taken, hold_pending;
      int          lat, consumed;

      reset = 1'b1;
      req_ready = 0; rsp_valid = 0; rsp_data = '0; redir_v = 0; redir_pc = '0; stall = 0;
      b_req_ready = 0; b_rsp_valid = 0; b_rsp_data = '0; b_redir_v = 0; b_redir_pc = '0; b_stall = 0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_req_valid", 32'(req_valid), 32'd0);
      check("rst_id_valid", 32'(id_valid), 32'd0);
      check("rst_id_instr", id_instr, NOP);
      check("rst_id_pc", id_pc, 32'd0);
      check("rst_id_pc4", id_pc4, 32'd0);

      // First fetch: one-cycle memory latency
      tick(); reset = 1'b0; req_ready = 1'b1;
      @(negedge clk);
      check("t1_req_valid", 32'(req_valid), 32'd1);
      check("t1_addr", addr, 32'd0);
      tick(); req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0050_0093;
      @(negedge clk);
      check("t1_wait_req", 32'(req_valid), 32'd0);
      tick(); rsp_valid = 1'b0;
      @(negedge clk);
      check("t1_id_valid", 32'(id_valid), 32'd1);
      check("t1_id_instr", id_instr, 32'h0050_0093);
      check("t1_id_pc", id_pc, 32'd0);
      check("t1_id_pc4", id_pc4, 32'd4);
      check("t1_next_addr", addr, 32'd4);

      // Redirect while waiting; the stale response must be dropped
      tick(); req_ready = 1'b1;
      tick(); req_ready = 1'b0; redir_v = 1'b1; redir_pc = 32'h100;
      tick(); redir_v = 1'b0;
      tick(); rsp_valid = 1'b1; rsp_data = 32'hBAD0_0001;
      @(negedge clk);
      check("t3_id_valid_a", 32'(id_valid), 32'd0);
      check("t3_req_valid_a", 32'(req_valid), 32'd0);
      tick(); rsp_valid = 1'b0;
      @(negedge clk);
      check("t3_id_valid_b", 32'(id_valid), 32'd0);
      check("t3_id_instr", id_instr, NOP);
      check("t3_req_valid_b", 32'(req_valid), 32'd1);
      check("t3_addr", addr, 32'h100);

      // Redirect coincident with response under stall
      tick(); req_ready = 1'b1;
      tick(); req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hBAD0_0002;
      stall = 1'b1; redir_v = 1'b1; redir_pc = 32'h200;
      tick(); rsp_valid = 1'b0; redir_v = 1'b0; stall = 1'b0;
      @(negedge clk);
      check("t4_id_valid", 32'(id_valid), 32'd0);
      check("t4_id_instr", id_instr, NOP);
      check("t4_req_valid", 32'(req_valid), 32'd1);
      check("t4_addr", addr, 32'h200);
      tick(); req_ready = 1'b1;
      tick(); req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = mem_word(32'h200);
      tick(); rsp_valid = 1'b0;
      @(negedge clk);
      check("t4_target_pc", id_pc, 32'h200);
      check("t4_target_instr", id_instr, mem_word(32'h200));

      // PC wrap on the second instance
      check("t5_first_addr", b_addr, 32'hFFFF_FFFC);
      tick(); b_req_ready = 1'b1;
      tick(); b_req_ready = 1'b0; b_rsp_valid = 1'b1; b_rsp_data = 32'h0050_0093;
      tick(); b_rsp_valid = 1'b0;
      @(negedge clk);
      check("t5_id_pc", b_id_pc, 32'hFFFF_FFFC);
      check("t5_id_pc4", b_id_pc4, 32'd0);
      check("t5_second_addr", b_addr, 32'd0);
      tick(); b_redir_v = 1'b1; b_redir_pc = 32'h103;
      tick(); b_redir_v = 1'b0;
      @(negedge clk);
      check("t5_redir_addr", b_addr, 32'h100);
      check("t5_redir_id_valid", 32'(b_id_valid), 32'd0);

      // Reset during WAIT with a late response afterwards
      tick(); req_ready = 1'b1;
      tick(); req_ready = 1'b0; reset = 1'b1;
      tick(); reset = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hBAD0_0003;
      @(negedge clk);
      check("t6_addr", addr, 32'd0);
      check("t6_req_valid", 32'(req_valid), 32'd1);
      check("t6_id_valid_a", 32'(id_valid), 32'd0);
      tick(); rsp_valid = 1'b0;
      @(negedge clk);
      check("t6_id_valid_b", 32'(id_valid), 32'd0);
      check("t6_addr_b", addr, 32'd0);

      // Randomized run against a program-order reference
      exp_pc = 32'd0; outst = 1'b0; o_addr = '0; lat = 0; consumed = 0; hold_pending = 1'b0;
      snap_instr = '0; snap_pc = '0; snap_pc4 = '0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         if (!id_valid) check("rnd_nop", id_instr, NOP);
         if (hold_pending) begin
            check("rnd_hold_valid", 32'(id_valid), 32'd1);
            check("rnd_hold_instr", id_instr, snap_instr);
            check("rnd_hold_pc", id_pc, snap_pc);
            check("rnd_hold_pc4", id_pc4, snap_pc4);
            hold_pending = 1'b0;
         end
         if (id_valid && !stall) begin
            check("rnd_pc", id_pc, exp_pc);
            check("rnd_instr", id_instr, mem_word(exp_pc));
            check("rnd_pc4", id_pc4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         if (id_valid && stall && !redir_v) begin
            snap_instr = id_instr; snap_pc = id_pc; snap_pc4 = id_pc4;
            hold_pending = 1'b1;
         end
         if (redir_v) exp_pc = redir_pc & 32'hFFFF_FFFC;
         if (req_valid) check("rnd_addr_align", {30'd0, addr[1:0]}, 32'd0);
         hs        = req_valid && req_ready;
         hs_addr   = addr;
         rsp_taken = rsp_valid && outst;
         tick();
         if (rsp_taken) outst = 1'b0;
         if (hs) begin
            outst  = 1'b1;
            o_addr = hs_addr;
            lat    = int'($urandom_range(0, 2));
         end
         req_ready = ($urandom % 10) < 6;
         stall     = ($urandom % 10) < 4;
         redir_v   = ($urandom % 20) == 0;
         redir_pc  = $urandom;
         if (outst) begin
            if (lat == 0) begin
               rsp_valid = 1'b1;
               rsp_data  = mem_word(o_addr);
            end else begin
               rsp_valid = 1'b0;
               rsp_data  = $urandom;
               lat--;
            end
         end else begin
            rsp_valid = ($urandom % 8) == 0;
            rsp_data  = 32'hDEAD_BEEF;
         end
      end
      check("rnd_progress", 32'(consumed >= 100), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
